// File: rtl/eth_rx_filter_pkg.sv
// eth_rx_filter_pkg: shared types and constants for the RX destination-MAC filter.
package eth_rx_filter_pkg;

    localparam int ETH_ADDR_BYTES = 6;
    localparam logic [7:0] ETH_BCAST_BYTE = 8'hff;

    typedef enum logic [1:0] {
        HDR    = 2'd0,
        REPLAY = 2'd1,
        PASS   = 2'd2,
        DROP   = 2'd3
    } rx_state_e;

    // Byte idx of a MAC in wire order; byte 0 is mac[47:40].
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        return mac[47 - 8 * int'(idx) -: 8];
    endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// eth_sat_counter: statistics counter that sticks at all-ones and clears synchronously.
module eth_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock50,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock50)
        r_count <= i_clear ? '0 : (i_inc & ~&r_count) ? r_count + 1'b1 : r_count;

    assign o_count = r_count;

endmodule

// File: rtl/eth_rx_addr_filter.sv
// eth_rx_addr_filter: RX AXIS destination-MAC filter (unicast/broadcast/multicast/promisc).
// Define ETH_RX_FILTER_STATS_EN to add saturating pass/drop/runt counters.
module eth_rx_addr_filter
    import eth_rx_filter_pkg::*;
#(
    parameter bit MATCH_BROADCAST = 1'b1,
    parameter int STAT_WIDTH      = 32
) (
    input  logic        clock50,
    input  logic        reset,
    input  logic [47:0] mac_addr,
    input  logic        promisc,
    input  logic        accept_multicast,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_dropped
`ifdef ETH_RX_FILTER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] rx_pass_count,
    output logic [STAT_WIDTH-1:0] rx_drop_count,
    output logic [STAT_WIDTH-1:0] rx_runt_count
`endif
);

    localparam logic [2:0] LAST_HDR_IDX = 3'(ETH_ADDR_BYTES - 1);

    if (STAT_WIDTH < 1) begin : g_bad_stat_width
        $error("STAT_WIDTH must be at least 1");
    end

    rx_state_e  r_state;
    logic [2:0] r_idx;
    logic [2:0] r_ridx;
    logic [7:0] r_hdr [ETH_ADDR_BYTES];
    logic       r_uc;
    logic       r_bc;
    logic       r_mc;
    logic       r_last_in_hdr;
    logic       r_user_in_hdr;
    logic [7:0] r_out_data;
    logic       r_out_last;
    logic       r_out_user;
    logic       r_dropped;

    logic       w_live;
    logic       w_pass;
    logic       w_hdr_hs;
    logic       w_uc;
    logic       w_bc;
    logic       w_mc;
    logic       w_hdr_end;
    logic       w_runt;
    logic       w_accept;
    logic       w_pass_dec;
    logic       w_rej_dec;
    logic [2:0] w_rnext;
    logic       w_rnext_last;

    assign w_live    = !reset;
    assign w_pass    = w_live & (r_state == PASS);
    assign w_hdr_hs  = (r_state == HDR) & s_axis_tvalid;
    // Flags fold in the byte being accepted so the decision can be made on byte 5 itself.
    assign w_uc      = r_uc & (s_axis_tdata == mac_byte(mac_addr, r_idx));
    assign w_bc      = r_bc & (s_axis_tdata == ETH_BCAST_BYTE);
    assign w_mc      = (r_idx == 3'd0) ? s_axis_tdata[0] : r_mc;
    assign w_hdr_end = w_hdr_hs & (r_idx == LAST_HDR_IDX);
    assign w_runt    = w_hdr_hs & s_axis_tlast & (r_idx != LAST_HDR_IDX);
    assign w_accept  = promisc | w_uc | (MATCH_BROADCAST & w_bc) | (accept_multicast & w_mc);
    assign w_pass_dec = w_hdr_end & w_accept;
    assign w_rej_dec  = w_hdr_end & !w_accept;
    assign w_rnext      = r_ridx + 3'd1;
    assign w_rnext_last = (w_rnext == LAST_HDR_IDX) & r_last_in_hdr;

    assign s_axis_tready = w_live & ((r_state == HDR) | (r_state == DROP) | (w_pass & m_axis_tready));
    assign m_axis_tvalid = w_live & (w_pass ? s_axis_tvalid : (r_state == REPLAY));
    assign m_axis_tdata  = !w_live ? 8'd0 : w_pass ? s_axis_tdata : r_out_data;
    assign m_axis_tlast  = w_live & (w_pass ? s_axis_tlast : r_out_last);
    assign m_axis_tuser  = w_live & (w_pass ? (s_axis_tuser & s_axis_tlast) : r_out_user);
    assign m_axis_tkeep  = 1'b1;
    assign frame_dropped = w_live & r_dropped;

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_state       <= HDR;
            r_idx         <= 3'd0;
            r_ridx        <= 3'd0;
            r_uc          <= 1'b1;
            r_bc          <= 1'b1;
            r_mc          <= 1'b0;
            r_last_in_hdr <= 1'b0;
            r_user_in_hdr <= 1'b0;
            r_out_data    <= 8'd0;
            r_out_last    <= 1'b0;
            r_out_user    <= 1'b0;
            r_dropped     <= 1'b0;
        end else begin
            r_dropped <= w_runt | w_rej_dec;
            case (r_state)
                HDR: if (s_axis_tvalid) begin
                    r_hdr[r_idx] <= s_axis_tdata;
                    r_idx        <= (w_runt | w_hdr_end) ? 3'd0 : r_idx + 3'd1;
                    r_uc         <= (w_runt | w_hdr_end) ? 1'b1 : w_uc;
                    r_bc         <= (w_runt | w_hdr_end) ? 1'b1 : w_bc;
                    r_mc         <= (w_runt | w_hdr_end) ? 1'b0 : w_mc;
                    if (w_pass_dec) begin
                        r_state       <= REPLAY;
                        r_last_in_hdr <= s_axis_tlast;
                        r_user_in_hdr <= s_axis_tuser;
                        r_ridx        <= 3'd0;
                        r_out_data    <= r_hdr[0];
                        r_out_last    <= 1'b0;
                        r_out_user    <= 1'b0;
                    end else if (w_rej_dec & !s_axis_tlast) begin
                        r_state <= DROP;
                    end
                end
                REPLAY: if (m_axis_tready) begin
                    if (r_ridx == LAST_HDR_IDX) begin
                        r_state    <= r_last_in_hdr ? HDR : PASS;
                        r_out_last <= 1'b0;
                        r_out_user <= 1'b0;
                    end else begin
                        r_ridx     <= w_rnext;
                        r_out_data <= r_hdr[w_rnext];
                        r_out_last <= w_rnext_last;
                        r_out_user <= w_rnext_last & r_user_in_hdr;
                    end
                end
                PASS: if (s_axis_tvalid & m_axis_tready & s_axis_tlast) r_state <= HDR;
                DROP: if (s_axis_tvalid & s_axis_tlast) r_state <= HDR;
            endcase
        end
    end

`ifdef ETH_RX_FILTER_STATS_EN
    eth_sat_counter #(.WIDTH(STAT_WIDTH)) u_pass_cnt (
        .clock50 (clock50),
        .i_clear (reset),
        .i_inc   (w_pass_dec),
        .o_count (rx_pass_count)
    );
    eth_sat_counter #(.WIDTH(STAT_WIDTH)) u_drop_cnt (
        .clock50 (clock50),
        .i_clear (reset),
        .i_inc   (w_rej_dec),
        .o_count (rx_drop_count)
    );
    eth_sat_counter #(.WIDTH(STAT_WIDTH)) u_runt_cnt (
        .clock50 (clock50),
        .i_clear (reset),
        .i_inc   (w_runt),
        .o_count (rx_runt_count)
    );
`endif

endmodule
